// File: rtl/edge_mcu_ctrl.sv
// edge_mcu_ctrl: master sequencer for the edge-detection datapath.
// Flow: memory read -> grayscale -> buffer-1 fill -> gradient -> buffer-2
// drain to memory writes. The image ends after TOTAL_WRITES completed writes.
//
// Handshake: every o_*_start / o_*_save strobe is high for exactly one cycle.
// Each downstream block answers with a single-cycle done pulse. A done pulse
// is accepted only in the state that waits for it and is dropped otherwise.
// o_re and o_we are levels that stay high while the FSM sits in READ or WRITE.
//
// Build option MCU_STOP_EN: when defined, i_stop aborts the sequence back to
// IDLE from any state except DONE. When undefined, i_stop is ignored.
//
// The FSM state is held in state_q (type mcu_state_e) so that checkers can
// bind to it directly.
module edge_mcu_ctrl #(
  parameter logic [31:0] RBASE        = 32'h0000_0000,
  parameter logic [31:0] WBASE        = 32'h0001_0000,
  parameter logic [31:0] ADDR_STEP    = 32'd4,
  parameter int unsigned TOTAL_WRITES = 180
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_stop,
  input  logic        i_read_complete,
  input  logic        i_grayscale_data_ready,
  input  logic        i_b1_full,
  input  logic        i_gradient_data_ready,
  input  logic        i_start_next_write,
  input  logic        i_write_complete,
  input  logic        i_b2_empty,
  output logic [31:0] o_mcu_raddr,
  output logic        o_re,
  output logic        o_grayscale_start,
  output logic        o_b1_save,
  output logic        o_gradient_start,
  output logic        o_b2_save,
  output logic [31:0] o_mcu_waddr,
  output logic        o_we,
  output logic        o_complete
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    READ       = 4'd1,
    GRAY_START = 4'd2,
    GRAY_WAIT  = 4'd3,
    B1_SAVE    = 4'd4,
    B1_CHECK   = 4'd5,
    GRAD_START = 4'd6,
    GRAD_WAIT  = 4'd7,
    B2_SAVE    = 4'd8,
    WR_WAIT    = 4'd9,
    WRITE      = 4'd10,
    DONE       = 4'd11
  } mcu_state_e;

  mcu_state_e  state_q, state_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wcount_q, wcount_d;
  logic        stop_req;

`ifdef MCU_STOP_EN
  // Abort request; DONE is terminal and only leaves through reset.
  assign stop_req = i_stop && (state_q != DONE);
`else
  // Abort disabled: the port is kept but nothing consumes it.
  logic unused_stop;
  assign unused_stop = i_stop;
  assign stop_req    = 1'b0;
`endif

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      raddr_q  <= RBASE;
      waddr_q  <= WBASE;
      wcount_q <= '0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wcount_q <= wcount_d;
    end
  end

  // Next-state, address and write-count logic; the abort overrides everything.
  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wcount_d = wcount_q;
    case (state_q)
      IDLE:       state_d = READ;
      READ: begin
        // A full buffer 1 takes priority over a completing read.
        if (i_b1_full) begin
          state_d = GRAD_START;
        end else if (i_read_complete) begin
          state_d = GRAY_START;
          raddr_d = raddr_q + ADDR_STEP;
        end
      end
      GRAY_START: state_d = GRAY_WAIT;
      GRAY_WAIT:  if (i_grayscale_data_ready) state_d = B1_SAVE;
      B1_SAVE:    state_d = B1_CHECK;
      // One settle cycle so i_b1_full reflects the word just saved.
      B1_CHECK:   state_d = i_b1_full ? GRAD_START : READ;
      GRAD_START: state_d = GRAD_WAIT;
      GRAD_WAIT:  if (i_gradient_data_ready) state_d = B2_SAVE;
      B2_SAVE:    state_d = WR_WAIT;
      WR_WAIT: begin
        if (i_b2_empty) begin
          state_d = READ;
        end else if (i_start_next_write) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (i_write_complete) begin
          waddr_d  = waddr_q + ADDR_STEP;
          wcount_d = wcount_q + 32'd1;
          state_d  = (wcount_d == TOTAL_WRITES) ? DONE : WR_WAIT;
        end
      end
      DONE:       state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (stop_req) begin
      state_d  = IDLE;
      raddr_d  = RBASE;
      waddr_d  = WBASE;
      wcount_d = '0;
    end
  end

  // Outputs decoded from registered state and counters only.
  assign o_mcu_raddr       = raddr_q;
  assign o_mcu_waddr       = waddr_q;
  assign o_re              = (state_q == READ);
  assign o_grayscale_start = (state_q == GRAY_START);
  assign o_b1_save         = (state_q == B1_SAVE);
  assign o_gradient_start  = (state_q == GRAD_START);
  assign o_b2_save         = (state_q == B2_SAVE);
  assign o_we              = (state_q == WRITE);
  assign o_complete        = (state_q == DONE);

endmodule

// File: tb/tb_edge_mcu_ctrl.sv
// Directed bench for edge_mcu_ctrl. Inputs change and outputs are sampled
// 1 ns after each rising clock edge. Expected values are hand-derived.
module tb_edge_mcu_ctrl;

  logic        clk;
  logic        n_rst;
  logic        i_stop;
  logic        i_read_complete;
  logic        i_grayscale_data_ready;
  logic        i_b1_full;
  logic        i_gradient_data_ready;
  logic        i_start_next_write;
  logic        i_write_complete;
  logic        i_b2_empty;
  logic [31:0] o_mcu_raddr;
  logic        o_re;
  logic        o_grayscale_start;
  logic        o_b1_save;
  logic        o_gradient_start;
  logic        o_b2_save;
  logic [31:0] o_mcu_waddr;
  logic        o_we;
  logic        o_complete;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_raddr;
  logic [31:0] exp_waddr;
  int          wcount;

  edge_mcu_ctrl dut (
    .clk                    (clk),
    .n_rst                  (n_rst),
    .i_stop                 (i_stop),
    .i_read_complete        (i_read_complete),
    .i_grayscale_data_ready (i_grayscale_data_ready),
    .i_b1_full              (i_b1_full),
    .i_gradient_data_ready  (i_gradient_data_ready),
    .i_start_next_write     (i_start_next_write),
    .i_write_complete       (i_write_complete),
    .i_b2_empty             (i_b2_empty),
    .o_mcu_raddr            (o_mcu_raddr),
    .o_re                   (o_re),
    .o_grayscale_start      (o_grayscale_start),
    .o_b1_save              (o_b1_save),
    .o_gradient_start       (o_gradient_start),
    .o_b2_save              (o_b2_save),
    .o_mcu_waddr            (o_mcu_waddr),
    .o_we                   (o_we),
    .o_complete             (o_complete)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_strobes(input string tag);
    check_eq({tag, "_gs"}, {31'd0, o_grayscale_start}, 32'd0);
    check_eq({tag, "_b1"}, {31'd0, o_b1_save}, 32'd0);
    check_eq({tag, "_gr"}, {31'd0, o_gradient_start}, 32'd0);
    check_eq({tag, "_b2"}, {31'd0, o_b2_save}, 32'd0);
  endtask

  // One read -> grayscale -> buffer-1 save round, starting in READ.
  task automatic read_round(input bit full_after);
    i_read_complete = 1'b1;
    step();
    i_read_complete = 1'b0;
    exp_raddr = exp_raddr + 32'd4;
    check_eq("gray_start", {31'd0, o_grayscale_start}, 32'd1);
    check_eq("raddr_inc", o_mcu_raddr, exp_raddr);
    check_eq("re_low", {31'd0, o_re}, 32'd0);
    step();
    check_eq("gray_start_1cyc", {31'd0, o_grayscale_start}, 32'd0);
    // A stray gradient pulse while waiting for grayscale is dropped.
    i_gradient_data_ready = 1'b1;
    step();
    i_gradient_data_ready = 1'b0;
    check_eq("stray_b1", {31'd0, o_b1_save}, 32'd0);
    check_eq("stray_b2", {31'd0, o_b2_save}, 32'd0);
    i_grayscale_data_ready = 1'b1;
    step();
    i_grayscale_data_ready = 1'b0;
    check_eq("b1_save", {31'd0, o_b1_save}, 32'd1);
    if (full_after) i_b1_full = 1'b1;
    step();
    check_eq("b1_save_1cyc", {31'd0, o_b1_save}, 32'd0);
    step();
    if (full_after) begin
      check_eq("chk_to_grad", {31'd0, o_gradient_start}, 32'd1);
      i_b1_full = 1'b0;
    end else begin
      check_eq("chk_to_read", {31'd0, o_re}, 32'd1);
    end
  endtask

  // From READ, buffer 1 full; optionally with a simultaneous read_complete.
  task automatic enter_grad_from_read(input bit both);
    i_b1_full = 1'b1;
    if (both) i_read_complete = 1'b1;
    step();
    i_b1_full       = 1'b0;
    i_read_complete = 1'b0;
    check_eq("grad_start", {31'd0, o_gradient_start}, 32'd1);
    check_eq("raddr_hold", o_mcu_raddr, exp_raddr);
  endtask

  // From GRAD_START through B2_SAVE into WR_WAIT.
  task automatic grad_phase();
    step();
    check_eq("grad_start_1cyc", {31'd0, o_gradient_start}, 32'd0);
    i_gradient_data_ready = 1'b1;
    step();
    i_gradient_data_ready = 1'b0;
    check_eq("b2_save", {31'd0, o_b2_save}, 32'd1);
    step();
    check_eq("b2_save_1cyc", {31'd0, o_b2_save}, 32'd0);
    check_eq("wrwait_we", {31'd0, o_we}, 32'd0);
  endtask

  // n write pairs from WR_WAIT; then b2_empty back to READ unless done.
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      i_start_next_write = 1'b1;
      step();
      i_start_next_write = 1'b0;
      check_eq("we_high", {31'd0, o_we}, 32'd1);
      step();
      check_eq("we_hold", {31'd0, o_we}, 32'd1);
      i_write_complete = 1'b1;
      step();
      i_write_complete = 1'b0;
      exp_waddr = exp_waddr + 32'd4;
      wcount++;
      check_eq("we_low", {31'd0, o_we}, 32'd0);
      check_eq("waddr_inc", o_mcu_waddr, exp_waddr);
      check_eq("complete", {31'd0, o_complete}, (wcount == 180) ? 32'd1 : 32'd0);
    end
    if (wcount != 180) begin
      i_b2_empty = 1'b1;
      step();
      i_b2_empty = 1'b0;
      check_eq("empty_to_read", {31'd0, o_re}, 32'd1);
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    n_vec = 0;
    n_err = 0;
    wcount = 0;
    n_rst = 1'b0;
    i_stop = 1'b0;
    i_read_complete = 1'b0;
    i_grayscale_data_ready = 1'b0;
    i_b1_full = 1'b0;
    i_gradient_data_ready = 1'b0;
    i_start_next_write = 1'b0;
    i_write_complete = 1'b0;
    i_b2_empty = 1'b0;
    step();
    step();
    check_eq("rst_re", {31'd0, o_re}, 32'd0);
    check_eq("rst_we", {31'd0, o_we}, 32'd0);
    check_eq("rst_complete", {31'd0, o_complete}, 32'd0);
    check_idle_strobes("rst");
    check_eq("rst_raddr", o_mcu_raddr, 32'h0000_0000);
    check_eq("rst_waddr", o_mcu_waddr, 32'h0001_0000);
    n_rst = 1'b1;
    step();
    check_eq("post_rst_re", {31'd0, o_re}, 32'd1);
    exp_raddr = 32'h0;
    exp_waddr = 32'h0001_0000;

    // Pass 1: 25 rounds, full, 9 writes.
    for (int r = 0; r < 25; r++) read_round(1'b0);
    check_eq("fill_raddr", o_mcu_raddr, 32'h0000_0064);
    enter_grad_from_read(1'b0);
    grad_phase();
    drain(9);
    check_eq("drain_waddr", o_mcu_waddr, 32'h0001_0024);

    // Passes 2..20: alternate B1_CHECK exit and READ priority exit.
    for (int p = 2; p <= 20; p++) begin
      read_round(p % 2 == 1);
      if (p % 2 == 0) enter_grad_from_read(1'b1);
      grad_phase();
      drain(9);
    end
    check_eq("final_waddr", o_mcu_waddr, 32'h0001_02D0);

    // DONE is held; pulses are ignored.
    for (int h = 0; h < 3; h++) begin
      i_read_complete = 1'b1;
      i_start_next_write = 1'b1;
      i_b1_full = 1'b1;
      i_stop = 1'b1;
      step();
      check_eq("done_hold", {31'd0, o_complete}, 32'd1);
      check_eq("done_re", {31'd0, o_re}, 32'd0);
      check_eq("done_we", {31'd0, o_we}, 32'd0);
      check_idle_strobes("done");
    end
    i_read_complete = 1'b0;
    i_start_next_write = 1'b0;
    i_b1_full = 1'b0;
    i_stop = 1'b0;

    // Asynchronous reset out of DONE.
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("arst_complete", {31'd0, o_complete}, 32'd0);
    check_eq("arst_raddr", o_mcu_raddr, 32'h0000_0000);
    check_eq("arst_waddr", o_mcu_waddr, 32'h0001_0000);
    step();
    n_rst = 1'b1;
    step();
    check_eq("rerun_re", {31'd0, o_re}, 32'd1);
    exp_raddr = 32'h0;
    exp_waddr = 32'h0001_0000;

    // Reach WRITE with raddr=4 and waddr=0x10004.
    read_round(1'b0);
    enter_grad_from_read(1'b0);
    grad_phase();
    i_start_next_write = 1'b1;
    step();
    i_start_next_write = 1'b0;
    i_write_complete = 1'b1;
    step();
    i_write_complete = 1'b0;
    check_eq("pre_abort_waddr", o_mcu_waddr, 32'h0001_0004);
    i_start_next_write = 1'b1;
    step();
    i_start_next_write = 1'b0;
    check_eq("pre_abort_we", {31'd0, o_we}, 32'd1);
    i_stop = 1'b1;
    step();
`ifdef MCU_STOP_EN
    check_eq("abort_we", {31'd0, o_we}, 32'd0);
    check_eq("abort_raddr", o_mcu_raddr, 32'h0000_0000);
    check_eq("abort_waddr", o_mcu_waddr, 32'h0001_0000);
    i_stop = 1'b0;
    step();
    check_eq("abort_re", {31'd0, o_re}, 32'd1);
`else
    check_eq("nostop_we", {31'd0, o_we}, 32'd1);
    check_eq("nostop_raddr", o_mcu_raddr, 32'h0000_0004);
    check_eq("nostop_waddr", o_mcu_waddr, 32'h0001_0004);
    i_stop = 1'b0;
    i_write_complete = 1'b1;
    step();
    i_write_complete = 1'b0;
    check_eq("nostop_we_low", {31'd0, o_we}, 32'd0);
    check_eq("nostop_waddr2", o_mcu_waddr, 32'h0001_0008);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
